unsigned_int_div32: RTL and testbench

- Sequential radix-2 restoring unsigned divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.
- Inverse of the combinational unsigned multiplier. A product z = x*y divided by x returns y with remainder 0.
- Iterative (one quotient bit per clock) with a start/ready/done handshake, so it sits beside the multiplier in the arithmetic datapath without a wide combinational divide.

---
 rtl/unsigned_int_div32_pkg.sv | 9 +
 rtl/unsigned_int_div32_if.sv | 25 ++
 rtl/unsigned_int_div32_step.sv | 20 ++
 rtl/unsigned_int_div32.sv | 83 ++++++++
 tb/tb_unsigned_int_div32.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/unsigned_int_div32_pkg.sv
// udiv_pkg: shared FSM state encoding, default operand width and counter sizing for the divider
package udiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 32;
  function automatic int cnt_w(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
  localparam int CNT_W = cnt_w(DEF_WIDTH);
endpackage

// File: rtl/unsigned_int_div32_if.sv
// unsigned_int_div32_if: start/ready/done request and result bundle between a requester and the divider
interface unsigned_int_div32_if
  import udiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic               start;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               ready;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               div_by_zero;
  logic               overflow;
  modport master (
    output start, dividend, divisor,
    input  ready, busy, done, quotient, remainder, div_by_zero, overflow
  );
  modport slave (
    input  start, dividend, divisor,
    output ready, busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/unsigned_int_div32_step.sv
// udiv_step: one combinational restoring-division step (shift in a bit, trial subtract, keep or restore)
module udiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   prem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   prem_nx,
  output logic             q_bit
);
  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;
  // the partial remainder is always below the divisor, so the shifted value fits W+1 bits and diff's MSB is a true sign
  always_comb begin
    sh      = {prem, bit_in};
    diff    = sh - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    prem_nx = q_bit ? diff[WIDTH:0] : sh[WIDTH:0];
  end
endmodule

// File: rtl/unsigned_int_div32.sv
// unsigned_int_div32: iterative radix-2 restoring divider, 2W/W -> W quotient + W remainder, one bit per clock.
// Optional macro UDIV_FASTPATH_EN: divisor==1 (high half 0) or dividend==0 completes straight from IDLE.
module unsigned_int_div32
  import udiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  unsigned_int_div32_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  state_t           state, state_nx;
  logic [WIDTH:0]   prem, prem_nx;
  logic [WIDTH-1:0] shreg, dvs_r, hi, lo, q_r, r_r;
  logic [CW-1:0]    cnt;
  logic             q_bit, zero_div, ovf_chk, fast, dbz_r, ovf_r;
  assign hi       = bus.dividend[2*WIDTH-1:WIDTH];
  assign lo       = bus.dividend[WIDTH-1:0];
  assign zero_div = bus.divisor == '0;
  assign ovf_chk  = hi >= bus.divisor;
`ifdef UDIV_FASTPATH_EN
  assign fast = (bus.divisor == WIDTH'(1) && hi == '0) || bus.dividend == '0;
`else
  assign fast = 1'b0;
`endif
  assign bus.ready       = state == IDLE;
  assign bus.busy        = state == RUN;
  assign bus.done        = state == DONE;
  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;
  udiv_step #(.WIDTH(WIDTH)) u_step (
    .prem    (prem),
    .bit_in  (shreg[WIDTH-1]),
    .divisor (dvs_r),
    .prem_nx (prem_nx),
    .q_bit   (q_bit)
  );
  // state register; reset aborts any division in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // next state: exceptional and fast-path requests skip RUN, DONE always returns to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (zero_div || ovf_chk || fast) ? DONE : RUN;
      RUN:     if (cnt == '0) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: shreg feeds dividend bits out of its MSB and collects quotient bits at its LSB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prem  <= '0;
      shreg <= '0;
      dvs_r <= '0;
      cnt   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      dbz_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      dbz_r <= zero_div;
      ovf_r <= !zero_div && ovf_chk;
      dvs_r <= bus.divisor;
      prem  <= {1'b0, hi};
      shreg <= lo;
      cnt   <= CW'(WIDTH - 1);
      q_r   <= (zero_div || ovf_chk) ? '1 : fast ? lo : q_r;
      r_r   <= zero_div ? lo : (ovf_chk || fast) ? '0 : r_r;
    end else if (state == RUN) begin
      prem  <= prem_nx;
      shreg <= {shreg[WIDTH-2:0], q_bit};
      cnt   <= cnt - 1'b1;
      if (cnt == '0) begin
        q_r <= {shreg[WIDTH-2:0], q_bit};
        r_r <= prem_nx[WIDTH-1:0];
      end
    end
endmodule

// File: tb/tb_unsigned_int_div32.sv
// tb_unsigned_int_div32: scoreboard bench, random and directed divisions checked against plain 64-bit arithmetic
module tb_unsigned_int_div32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  unsigned_int_div32_if #(.WIDTH(32)) bus ();
  unsigned_int_div32 #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];
  exp_t e_m;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [63:0] dvd, input logic [31:0] dvs);
    exp_t e;
    logic [63:0] d64;
    e.dbz = 1'b0; e.ovf = 1'b0; e.lat = 33; e.acc = 0;
    d64 = {32'd0, dvs};
    if (dvs == 0) begin
      e.q = '1; e.r = dvd[31:0]; e.dbz = 1'b1; e.lat = 1;
    end else if ((dvd >> 32) >= d64) begin
      e.q = '1; e.r = '0; e.ovf = 1'b1; e.lat = 1;
    end else begin
      e.q = 32'(dvd / d64);
      e.r = 32'(dvd % d64);
`ifdef UDIV_FASTPATH_EN
      if (dvs == 1 || dvd == 0) e.lat = 1;
`endif
    end
    return e;
  endfunction
  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk)
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected done=0");
      end else begin
        e_m = sb.pop_front();
        chk("quotient", 64'(bus.quotient), 64'(e_m.q));
        chk("remainder", 64'(bus.remainder), 64'(e_m.r));
        chk("div_by_zero", 64'(bus.div_by_zero), 64'(e_m.dbz));
        chk("overflow", 64'(bus.overflow), 64'(e_m.ovf));
        chk("latency", 64'(cyc - e_m.acc + 1), 64'(e_m.lat));
      end
    end
  task automatic issue(input logic [63:0] dvd, input logic [31:0] dvs);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!bus.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ready) begin
      chk("ready_timeout", 64'(bus.ready), 64'd1);
      return;
    end
    bus.start = 1'b1;
    bus.dividend = dvd;
    bus.divisor = dvs;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = {$urandom, $urandom};
    bus.divisor = $urandom;
    e = model(dvd, dvs);
    e.acc = cyc;
    sb.push_back(e);
  endtask
  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !bus.ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || !bus.ready) begin
      chk("idle_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask
  initial begin
    int t;
    int mode;
    logic [31:0] x, y, hi;
    logic [63:0] dvd;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_quotient", 64'(bus.quotient), 64'd0);
    chk("rst_remainder", 64'(bus.remainder), 64'd0);
    chk("rst_flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
    rst_n = 1'b1;
    issue(64'h9, 32'h3);
    wait_idle();
    issue(64'h64, 32'h7);
    issue(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
    issue(64'h1234, 32'h0);
    issue(64'h1_0000_0000, 32'h1);
    issue(64'h0000_0000_DEAD_BEEF, 32'h1);
    issue(64'h0, 32'h5);
    wait_idle();
    issue(64'h64, 32'h7);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 64'd500;
    bus.divisor = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      chk("ready_low_run_done", 64'(bus.ready), 64'd0);
      t++;
    end while (!bus.done && t < 60);
    if (!bus.done) chk("done_timeout", 64'(bus.done), 64'd1);
    wait_idle();
    repeat (40) @(negedge clk);
    issue(64'h64, 32'h7);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_quotient", 64'(bus.quotient), 64'd0);
    chk("abort_remainder", 64'(bus.remainder), 64'd0);
    chk("abort_ready", 64'(bus.ready), 64'd1);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    repeat (40) @(negedge clk);
    issue(64'h9, 32'h3);
    wait_idle();
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 5);
      x = $urandom;
      y = $urandom;
      hi = $urandom;
      case (mode)
        0: begin dvd = {32'd0, x} * {32'd0, y}; end
        1: begin dvd = {(x == 0) ? 32'd0 : hi % x, y}; end
        2: begin x = $urandom_range(1, 255); dvd = {hi % x, y}; end
        3: begin dvd = {hi, y}; x = 32'd0; end
        4: begin dvd = {x | hi, y}; end
        default: begin
          if (y[0]) begin x = 32'd1; dvd = {32'd0, hi}; end
          else dvd = 64'd0;
        end
      endcase
      issue(dvd, x);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
